// File: rtl/count_window_monitor_if.sv
// Signal bundle between a count producer (master) and count_window_monitor (slave).
// Carries the sampled count, threshold configuration and all monitor status outputs.
interface count_window_monitor_if #(
    parameter int N    = 8,
    parameter int WC_W = 4
);
    logic [N-1:0]    count;
    logic [N-1:0]    lo_thr;
    logic [N-1:0]    hi_thr;
    logic            clr;
    logic [1:0]      zone;
    logic            lo_evt;
    logic            hi_evt;
    logic            wrap_up;
    logic            wrap_dn;
    logic [WC_W-1:0] wrap_cnt;
    logic            cfg_err;

    modport master (
        output count, lo_thr, hi_thr, clr,
        input  zone, lo_evt, hi_evt, wrap_up, wrap_dn, wrap_cnt, cfg_err
    );

    modport slave (
        input  count, lo_thr, hi_thr, clr,
        output zone, lo_evt, hi_evt, wrap_up, wrap_dn, wrap_cnt, cfg_err
    );
endinterface

// File: rtl/count_window_monitor.sv
// Passive observer of an N-bit up/down counter: detects wrap-arounds (with a saturating
// tally) and tracks LOW/MID/HIGH threshold zones with hysteresis and entry pulses.
module count_window_monitor #(
    parameter int N    = 8,
    parameter int HYST = 2,
    parameter int WC_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    count_window_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        ZONE_INIT = 2'b00,
        ZONE_LOW  = 2'b01,
        ZONE_MID  = 2'b10,
        ZONE_HIGH = 2'b11
    } zone_t;

    localparam logic [N-1:0]    CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0]    HYST_N  = N'(HYST);
    localparam logic [WC_W-1:0] WC_MAX  = {WC_W{1'b1}};

    logic [N-1:0]    count_q;
    logic [N-1:0]    prev_q;
    logic [1:0]      smp_vld;

    zone_t           zone_q;
    zone_t           zone_d;
    logic            lo_evt_q, lo_evt_d;
    logic            hi_evt_q, hi_evt_d;
    logic            wrap_up_q, wrap_up_d;
    logic            wrap_dn_q, wrap_dn_d;
    logic [WC_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic            cfg_err_q;
    logic            cfg_now;
    logic [N-1:0]    hi_exit;
    logic [N-1:0]    lo_exit;
    logic            pair_vld;

    // Stage 1: sample the counter and remember the previous sample; smp_vld fills
    // with ones so the (prev_q, count_q) pair is trusted only once both are real samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            prev_q  <= '0;
            smp_vld <= 2'b00;
        end else begin
            count_q <= mon.count;
            prev_q  <= count_q;
            smp_vld <= {smp_vld[0], 1'b1};
        end
    end

    assign pair_vld = (smp_vld == 2'b11);
    assign cfg_now  = (mon.lo_thr >= mon.hi_thr);

    // Hysteresis exit points, clamped so they never wrap around the count range.
    always_comb begin
        hi_exit = (mon.hi_thr > HYST_N) ? (mon.hi_thr - HYST_N) : '0;
        lo_exit = (mon.lo_thr > (CNT_MAX - HYST_N)) ? CNT_MAX : (mon.lo_thr + HYST_N);
    end

    always_comb begin
        wrap_up_d  = pair_vld && (prev_q == CNT_MAX) && (count_q == '0);
        wrap_dn_d  = pair_vld && (prev_q == '0) && (count_q == CNT_MAX);
        wrap_cnt_d = wrap_cnt_q;
        if (mon.clr) begin
            wrap_cnt_d = '0;
        end else if ((wrap_up_d || wrap_dn_d) && (wrap_cnt_q != WC_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + WC_W'(1);
        end
    end

    // Zone FSM next state; a bad threshold pair parks it in INIT so it reclassifies later.
    always_comb begin
        zone_d   = zone_q;
        lo_evt_d = 1'b0;
        hi_evt_d = 1'b0;
        if (cfg_now) begin
            zone_d = ZONE_INIT;
        end else if (pair_vld) begin
            case (zone_q)
                ZONE_INIT: begin
                    if (count_q >= mon.hi_thr)      zone_d = ZONE_HIGH;
                    else if (count_q <= mon.lo_thr) zone_d = ZONE_LOW;
                    else                            zone_d = ZONE_MID;
                end
                ZONE_MID: begin
                    if (count_q >= mon.hi_thr)      zone_d = ZONE_HIGH;
                    else if (count_q <= mon.lo_thr) zone_d = ZONE_LOW;
                end
                ZONE_HIGH: begin
                    if (count_q <= mon.lo_thr)      zone_d = ZONE_LOW;
                    else if (count_q < hi_exit)     zone_d = ZONE_MID;
                end
                ZONE_LOW: begin
                    if (count_q >= mon.hi_thr)      zone_d = ZONE_HIGH;
                    else if (count_q > lo_exit)     zone_d = ZONE_MID;
                end
                default: zone_d = ZONE_INIT;
            endcase
            lo_evt_d = (zone_d == ZONE_LOW)  && (zone_q != ZONE_LOW);
            hi_evt_d = (zone_d == ZONE_HIGH) && (zone_q != ZONE_HIGH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zone_q <= ZONE_INIT;
        end else begin
            zone_q <= zone_d;
        end
    end

    // Stage 2: every status output is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_evt_q   <= 1'b0;
            hi_evt_q   <= 1'b0;
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            wrap_cnt_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            lo_evt_q   <= lo_evt_d;
            hi_evt_q   <= hi_evt_d;
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            wrap_cnt_q <= wrap_cnt_d;
            cfg_err_q  <= cfg_now;
        end
    end

    assign mon.zone     = zone_q;
    assign mon.lo_evt   = lo_evt_q;
    assign mon.hi_evt   = hi_evt_q;
    assign mon.wrap_up  = wrap_up_q;
    assign mon.wrap_dn  = wrap_dn_q;
    assign mon.wrap_cnt = wrap_cnt_q;
    assign mon.cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_count_window_monitor.sv
// Directed bench for count_window_monitor: reset, zone hysteresis, wraps, saturation,
// clear priority, threshold misconfiguration and mid-run reset.
module tb_count_window_monitor;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    count_window_monitor_if #(.N(8), .WC_W(4)) mon ();

    count_window_monitor #(.N(8), .HYST(2), .WC_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {zone, lo_evt, hi_evt, wrap_up, wrap_dn, wrap_cnt, cfg_err}
    logic [10:0] observed;
    assign observed = {mon.zone, mon.lo_evt, mon.hi_evt, mon.wrap_up, mon.wrap_dn,
                       mon.wrap_cnt, mon.cfg_err};

    localparam logic [1:0] Z_INIT = 2'b00, Z_LOW = 2'b01, Z_MID = 2'b10, Z_HIGH = 2'b11;

    function automatic logic [10:0] pack(input logic [1:0] z, input logic lo, input logic hi,
                                         input logic up, input logic dn,
                                         input logic [3:0] cnt, input logic err);
        return {z, lo, hi, up, dn, cnt, err};
    endfunction

    // Present a count value, then sample one time unit after the next rising edge.
    task automatic apply_count(input logic [7:0] v);
        mon.count = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [10:0] exp;
        reset = 1'b0;
        mon.count = 8'd50; mon.lo_thr = 8'd20; mon.hi_thr = 8'd200; mon.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp = pack(Z_INIT, 0, 0, 0, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL reset_hold: got %h expected %h", observed, exp); end
        reset = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            apply_count(8'd50);
            exp = (e < 3) ? pack(Z_INIT, 0, 0, 0, 0, 4'd0, 0) : pack(Z_MID, 0, 0, 0, 0, 4'd0, 0);
            checks++;
            if (observed !== exp) begin errors++; $display("FAIL release_edge%0d: got %h expected %h", e, observed, exp); end
        end
    endtask

    task automatic test_high_hysteresis;
        logic [10:0] exp;
        for (int v = 195; v <= 205; v++) begin
            apply_count(8'(v));
            exp = pack(((v - 1) >= 200) ? Z_HIGH : Z_MID, 0, ((v - 1) == 200), 0, 0, 4'd0, 0);
            checks++;
            if (observed !== exp) begin errors++; $display("FAIL ramp_up_%0d: got %h expected %h", v, observed, exp); end
        end
        apply_count(8'd199);
        apply_count(8'd198);
        apply_count(8'd197);
        exp = pack(Z_HIGH, 0, 0, 0, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL hyst_hold_198: got %h expected %h", observed, exp); end
        apply_count(8'd197);
        exp = pack(Z_MID, 0, 0, 0, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL hyst_exit_197: got %h expected %h", observed, exp); end
    endtask

    task automatic test_wrap_up;
        logic [10:0] exp;
        apply_count(8'd254);
        apply_count(8'd255);
        exp = pack(Z_HIGH, 0, 1, 0, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL wu_enter_high: got %h expected %h", observed, exp); end
        apply_count(8'd0);
        apply_count(8'd1);
        exp = pack(Z_LOW, 1, 0, 1, 0, 4'd1, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL wu_pulse: got %h expected %h", observed, exp); end
        apply_count(8'd1);
        exp = pack(Z_LOW, 0, 0, 0, 0, 4'd1, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL wu_one_cycle: got %h expected %h", observed, exp); end
    endtask

    task automatic test_wrap_dn;
        logic [10:0] exp;
        apply_count(8'd2);
        apply_count(8'd1);
        apply_count(8'd0);
        apply_count(8'd255);
        exp = pack(Z_LOW, 0, 0, 0, 0, 4'd1, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL wd_pre: got %h expected %h", observed, exp); end
        apply_count(8'd255);
        exp = pack(Z_HIGH, 0, 1, 0, 1, 4'd2, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL wd_pulse: got %h expected %h", observed, exp); end
        apply_count(8'd255);
        exp = pack(Z_HIGH, 0, 0, 0, 0, 4'd2, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL wd_one_cycle: got %h expected %h", observed, exp); end
    endtask

    task automatic test_saturation_clear;
        logic [10:0] exp;
        logic [4:0]  wexp;
        mon.clr = 1'b1;
        apply_count(8'd255);
        mon.clr = 1'b0;
        checks++;
        if (mon.wrap_cnt !== 4'd0) begin errors++; $display("FAIL clr_plain: got %0d expected 0", mon.wrap_cnt); end
        for (int i = 1; i <= 17; i++) begin
            apply_count(8'd255);
            apply_count(8'd0);
            apply_count(8'd128);
            wexp = {1'b1, (i > 15) ? 4'd15 : 4'(i)};
            checks++;
            if ({mon.wrap_up, mon.wrap_cnt} !== wexp) begin
                errors++; $display("FAIL sat_wrap_%0d: got %h expected %h", i, {mon.wrap_up, mon.wrap_cnt}, wexp);
            end
        end
        apply_count(8'd255);
        apply_count(8'd0);
        mon.clr = 1'b1;
        apply_count(8'd128);
        mon.clr = 1'b0;
        exp = pack(Z_LOW, 1, 0, 1, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL clr_on_wrap: got %h expected %h", observed, exp); end
        apply_count(8'd128);
        exp = pack(Z_MID, 0, 0, 0, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL clr_after: got %h expected %h", observed, exp); end
        apply_count(8'd255);
        apply_count(8'd0);
        apply_count(8'd128);
        checks++;
        if ({mon.wrap_up, mon.wrap_cnt} !== 5'h11) begin
            errors++; $display("FAIL recount: got %h expected 11", {mon.wrap_up, mon.wrap_cnt});
        end
    endtask

    task automatic test_cfg_err;
        logic [10:0] exp;
        mon.lo_thr = 8'd100; mon.hi_thr = 8'd100;
        apply_count(8'd100);
        exp = pack(Z_INIT, 0, 0, 0, 0, 4'd1, 1);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL cfg_enter: got %h expected %h", observed, exp); end
        apply_count(8'd100);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL cfg_hold: got %h expected %h", observed, exp); end
        apply_count(8'd255);
        apply_count(8'd0);
        apply_count(8'd100);
        exp = pack(Z_INIT, 0, 0, 1, 0, 4'd2, 1);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL cfg_wrap: got %h expected %h", observed, exp); end
        mon.lo_thr = 8'd20; mon.hi_thr = 8'd200;
        apply_count(8'd100);
        exp = pack(Z_MID, 0, 0, 0, 0, 4'd2, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL cfg_recover: got %h expected %h", observed, exp); end
    endtask

    task automatic test_mid_reset;
        logic [10:0] exp;
        apply_count(8'd50);
        apply_count(8'd51);
        reset = 1'b0;
        #2;
        exp = pack(Z_INIT, 0, 0, 0, 0, 4'd0, 0);
        checks++;
        if (observed !== exp) begin errors++; $display("FAIL async_reset: got %h expected %h", observed, exp); end
        mon.count = 8'd255;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            apply_count(8'd255);
            if (e < 3)       exp = pack(Z_INIT, 0, 0, 0, 0, 4'd0, 0);
            else if (e == 3) exp = pack(Z_HIGH, 0, 1, 0, 0, 4'd0, 0);
            else             exp = pack(Z_HIGH, 0, 0, 0, 0, 4'd0, 0);
            checks++;
            if (observed !== exp) begin errors++; $display("FAIL startup_edge%0d: got %h expected %h", e, observed, exp); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_high_hysteresis();
        test_wrap_up();
        test_wrap_dn();
        test_saturation_clear();
        test_cfg_err();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
